// File: rtl/wrst_sequencer_if.sv
// -----------------------------------------------------------------------------
// wrst_sequencer_if
//   Bundles the request/acknowledge handshake and the write-domain control
//   outputs of the write-side reset sequencer.
//
//   rst_req     : level request for a reset sequence (four-phase handshake)
//   rst_ack     : high while a completed sequence is acknowledged
//   fifo_wrst_n : active-low reset to the FIFO write domain
//   wr_allow    : high when the write side may issue writes
//   busy        : high whenever the sequencer is not idle
//   rst_count   : saturating count of completed sequences
//
//   master : the requester (drives rst_req, observes everything else)
//   slave  : the sequencer itself
// -----------------------------------------------------------------------------
interface wrst_sequencer_if #(
  parameter int CNT_OUT_W = 16
);
  logic                 rst_req;
  logic                 rst_ack;
  logic                 fifo_wrst_n;
  logic                 wr_allow;
  logic                 busy;
  logic [CNT_OUT_W-1:0] rst_count;

  modport master (
    output rst_req,
    input  rst_ack, fifo_wrst_n, wr_allow, busy, rst_count
  );

  modport slave (
    input  rst_req,
    output rst_ack, fifo_wrst_n, wr_allow, busy, rst_count
  );
endinterface

// File: rtl/wrst_sequencer.sv
// -----------------------------------------------------------------------------
// wrst_sequencer
//   Write-domain reset sequencer. Holds fifo_wrst_n low for ASSERT_CYCLES
//   cycles, then keeps writes blocked for RECOVERY_CYCLES more cycles before
//   acknowledging. One sequence runs automatically after wrst, and one more
//   per accepted rst_req/rst_ack four-phase handshake.
//
//   Ports:
//     wclk : the single clock, rising edge
//     wrst : synchronous active-high reset; overrides everything, restarts
//            the sequence
//     bus  : wrst_sequencer_if.slave (rst_req in; rst_ack, fifo_wrst_n,
//            wr_allow, busy, rst_count out)
//
//   All outputs are decoded from registers only; rst_req has no
//   combinational path to any output.
// -----------------------------------------------------------------------------
module wrst_sequencer #(
  parameter int ASSERT_CYCLES   = 4,
  parameter int RECOVERY_CYCLES = 2,
  parameter int CNT_W           = 8,
  parameter int CNT_OUT_W       = 16
) (
  input  logic               wclk,
  input  logic               wrst,
  wrst_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_RECOVER,
    S_DONE
  } state_e;

  // Counter load values: the counter runs N-1 down to 0, giving N cycles.
  localparam logic [CNT_W-1:0] ASSERT_LOAD = CNT_W'(ASSERT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REC_LOAD    =
      (RECOVERY_CYCLES > 0) ? CNT_W'(RECOVERY_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0]     CNT_ONE   = 1;
  localparam logic [CNT_OUT_W-1:0] COUNT_ONE = 1;

  state_e               state_q,     state_d;
  logic [CNT_W-1:0]     cnt_q,       cnt_d;
  logic [CNT_OUT_W-1:0] rst_count_q, rst_count_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      // Reset lands directly in ASSERT so the post-reset sequence starts on
      // the reset edge itself.
      state_q     <= S_ASSERT;
      cnt_q       <= ASSERT_LOAD;
      rst_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rst_count_q <= rst_count_d;
    end
  end

  // NOTE: every variable assigned here gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rst_count_d = rst_count_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.rst_req) begin
          state_d = S_ASSERT;
          cnt_d   = ASSERT_LOAD;
        end
      end

      // rst_req is deliberately not looked at in ASSERT or RECOVER: a
      // glitchy request can neither stretch nor restart a running sequence.
      S_ASSERT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else if (RECOVERY_CYCLES > 0) begin
          state_d = S_RECOVER;
          cnt_d   = REC_LOAD;
        end else begin
          state_d = S_DONE;
          if (rst_count_q != '1) rst_count_d = rst_count_q + COUNT_ONE;
        end
      end

      S_RECOVER: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = S_DONE;
          if (rst_count_q != '1) rst_count_d = rst_count_q + COUNT_ONE;
        end
      end

      // Hold the acknowledge until the requester drops rst_req; with no
      // request pending this is a single-cycle pulse.
      S_DONE: begin
        if (!bus.rst_req) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.fifo_wrst_n = (state_q != S_ASSERT);
  assign bus.wr_allow    = (state_q == S_IDLE);
  assign bus.rst_ack     = (state_q == S_DONE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.rst_count   = rst_count_q;

endmodule

// File: tb/tb_wrst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_wrst_sequencer
//   Three sequencer instances: the default build, a narrow-counter build
//   (CNT_OUT_W=2) for saturation, and a RECOVERY_CYCLES=0 build. Expected
//   fifo_wrst_n rise cycles and rst_ack rise cycles/counts are queued when
//   stimulus is driven and popped by monitors when the DUT shows the event.
//   Inputs change and outputs are sampled on the falling edge; cyc holds the
//   number of rising edges seen so far.
// -----------------------------------------------------------------------------
module tb_wrst_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic m_wrst = 1'b1;
  logic s_wrst = 1'b1;
  logic z_wrst = 1'b1;

  wrst_sequencer_if #(.CNT_OUT_W(16)) m_if ();
  wrst_sequencer_if #(.CNT_OUT_W(2))  s_if ();
  wrst_sequencer_if #(.CNT_OUT_W(16)) z_if ();

  wrst_sequencer #(.ASSERT_CYCLES(4), .RECOVERY_CYCLES(2), .CNT_W(8), .CNT_OUT_W(16))
    u_main (.wclk(clk), .wrst(m_wrst), .bus(m_if));
  wrst_sequencer #(.ASSERT_CYCLES(4), .RECOVERY_CYCLES(2), .CNT_W(8), .CNT_OUT_W(2))
    u_sat  (.wclk(clk), .wrst(s_wrst), .bus(s_if));
  wrst_sequencer #(.ASSERT_CYCLES(4), .RECOVERY_CYCLES(0), .CNT_W(8), .CNT_OUT_W(16))
    u_zero (.wclk(clk), .wrst(z_wrst), .bus(z_if));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int unsigned c);
    while (cyc < c) @(negedge clk);
  endtask

  typedef struct {
    int unsigned cyc;
    int unsigned cnt;
  } ack_t;

  ack_t        m_ack_q[$];
  ack_t        s_ack_q[$];
  ack_t        z_ack_q[$];
  int unsigned m_rise_q[$];
  int unsigned z_rise_q[$];

  logic m_ack_p = 1'b0, m_fifo_p = 1'b0;
  logic s_ack_p = 1'b0;
  logic z_ack_p = 1'b0, z_fifo_p = 1'b0;

  // Scoreboard monitors: an event with nothing queued is itself a failure.
  always @(negedge clk) begin : mon
    ack_t        e;
    int unsigned r;
    if (m_if.rst_ack === 1'b1 && m_ack_p !== 1'b1) begin
      if (m_ack_q.size() == 0) check("m_ack_unexpected", cyc, 0);
      else begin
        e = m_ack_q.pop_front();
        check("m_ack_cyc", cyc, e.cyc);
        check("m_ack_cnt", 32'(m_if.rst_count), e.cnt);
      end
    end
    if (m_if.fifo_wrst_n === 1'b1 && m_fifo_p !== 1'b1) begin
      if (m_rise_q.size() == 0) check("m_rise_unexpected", cyc, 0);
      else begin
        r = m_rise_q.pop_front();
        check("m_rise_cyc", cyc, r);
      end
    end
    if (s_if.rst_ack === 1'b1 && s_ack_p !== 1'b1) begin
      if (s_ack_q.size() == 0) check("s_ack_unexpected", cyc, 0);
      else begin
        e = s_ack_q.pop_front();
        check("s_ack_cyc", cyc, e.cyc);
        check("s_ack_cnt", 32'(s_if.rst_count), e.cnt);
      end
    end
    if (z_if.rst_ack === 1'b1 && z_ack_p !== 1'b1) begin
      if (z_ack_q.size() == 0) check("z_ack_unexpected", cyc, 0);
      else begin
        e = z_ack_q.pop_front();
        check("z_ack_cyc", cyc, e.cyc);
        check("z_ack_cnt", 32'(z_if.rst_count), e.cnt);
      end
    end
    if (z_if.fifo_wrst_n === 1'b1 && z_fifo_p !== 1'b1) begin
      if (z_rise_q.size() == 0) check("z_rise_unexpected", cyc, 0);
      else begin
        r = z_rise_q.pop_front();
        check("z_rise_cyc", cyc, r);
      end
    end
    m_ack_p  = m_if.rst_ack;
    m_fifo_p = m_if.fifo_wrst_n;
    s_ack_p  = s_if.rst_ack;
    z_ack_p  = z_if.rst_ack;
    z_fifo_p = z_if.fifo_wrst_n;
  end

  initial begin
    int unsigned c, k, n;
    m_if.rst_req = 1'b0;
    s_if.rst_req = 1'b0;
    z_if.rst_req = 1'b0;

    // ---- Power-on: wrst held for edges 1..3, so j = 3 ----
    wait_until(3);
    check("po_fifo_n",   m_if.fifo_wrst_n, 0);
    check("po_wr_allow", m_if.wr_allow,    0);
    check("po_busy",     m_if.busy,        1);
    check("po_ack",      m_if.rst_ack,     0);
    check("po_count",    m_if.rst_count,   0);
    m_wrst = 1'b0;
    m_rise_q.push_back(7);
    m_ack_q.push_back('{cyc: 9, cnt: 1});
    wait_until(6);
    check("po_fifo_low_j3", m_if.fifo_wrst_n, 0);
    wait_until(9);
    check("po_ack_hi",   m_if.rst_ack,  1);
    check("po_wr_block", m_if.wr_allow, 0);
    wait_until(10);
    check("po_ack_pulse", m_if.rst_ack,   0);
    check("po_wr_allow1", m_if.wr_allow,  1);
    check("po_idle",      m_if.busy,      0);
    check("po_count1",    m_if.rst_count, 1);

    // ---- Single request accepted at edge 13, held for 10 cycles ----
    wait_until(12);
    m_if.rst_req = 1'b1;
    m_rise_q.push_back(17);
    m_ack_q.push_back('{cyc: 19, cnt: 2});
    wait_until(13);
    check("req_fifo_n",   m_if.fifo_wrst_n, 0);
    check("req_busy",     m_if.busy,        1);
    check("req_wr_allow", m_if.wr_allow,    0);
    wait_until(22);
    check("req_ack_held", m_if.rst_ack, 1);
    m_if.rst_req = 1'b0;
    wait_until(23);
    check("req_ack_rel",  m_if.rst_ack,   0);
    check("req_wr_allow", m_if.wr_allow,  1);
    check("req_idle",     m_if.busy,      0);
    check("req_count",    m_if.rst_count, 2);

    // ---- Request jitter during ASSERT/RECOVER (k = 26) ----
    wait_until(25);
    m_if.rst_req = 1'b1;
    m_rise_q.push_back(30);
    m_ack_q.push_back('{cyc: 32, cnt: 3});
    for (int t = 27; t <= 31; t++) begin
      wait_until(t);
      check("jit_busy", m_if.busy,    1);
      check("jit_ack",  m_if.rst_ack, 0);
      m_if.rst_req = (t % 2 == 0);
    end
    wait_until(33);
    check("jit_ack_rel",  m_if.rst_ack,   0);
    check("jit_wr_allow", m_if.wr_allow,  1);
    wait_until(35);
    check("jit_count",    m_if.rst_count, 3);

    // ---- Mid-sequence reset on the 2nd ASSERT cycle (k = 37, j = 39) ----
    wait_until(36);
    m_if.rst_req = 1'b1;
    wait_until(37);
    check("mid_fifo_n", m_if.fifo_wrst_n, 0);
    wait_until(38);
    m_wrst       = 1'b1;
    m_if.rst_req = 1'b0;
    m_rise_q.push_back(43);
    m_ack_q.push_back('{cyc: 45, cnt: 1});
    wait_until(39);
    m_wrst = 1'b0;
    check("mid_count0", m_if.rst_count,   0);
    check("mid_fifo_n", m_if.fifo_wrst_n, 0);
    check("mid_busy",   m_if.busy,        1);
    wait_until(42);
    check("mid_fifo_low", m_if.fifo_wrst_n, 0);
    wait_until(46);
    check("mid_ack_rel",  m_if.rst_ack,   0);
    check("mid_wr_allow", m_if.wr_allow,  1);
    check("mid_count1",   m_if.rst_count, 1);

    // ---- Saturation on the 2-bit counter build (j = 50) ----
    wait_until(50);
    s_wrst = 1'b0;
    s_ack_q.push_back('{cyc: 56, cnt: 1});
    wait_until(57);
    check("sat_count_po", s_if.rst_count, 1);
    check("sat_wr_allow", s_if.wr_allow,  1);
    n = 1;
    c = 57;
    for (int i = 0; i < 5; i++) begin
      wait_until(c);
      s_if.rst_req = 1'b1;
      k = c + 1;
      n++;
      s_ack_q.push_back('{cyc: k + 6, cnt: (n > 3) ? 3 : n});
      wait_until(k + 6);
      s_if.rst_req = 1'b0;
      wait_until(k + 7);
      check("sat_count", s_if.rst_count, (n > 3) ? 3 : n);
      c = k + 7;
    end

    // ---- RECOVERY_CYCLES = 0 build (j = 100, then k = 107) ----
    wait_until(100);
    z_wrst = 1'b0;
    z_rise_q.push_back(104);
    z_ack_q.push_back('{cyc: 104, cnt: 1});
    wait_until(103);
    check("z_po_fifo_lo", z_if.fifo_wrst_n, 0);
    check("z_po_ack_lo",  z_if.rst_ack,     0);
    wait_until(104);
    check("z_po_fifo_hi", z_if.fifo_wrst_n, 1);
    check("z_po_ack_hi",  z_if.rst_ack,     1);
    wait_until(105);
    check("z_po_wr_allow", z_if.wr_allow, 1);
    check("z_po_ack_rel",  z_if.rst_ack,  0);
    wait_until(106);
    z_if.rst_req = 1'b1;
    z_rise_q.push_back(111);
    z_ack_q.push_back('{cyc: 111, cnt: 2});
    wait_until(110);
    check("z_req_fifo_lo", z_if.fifo_wrst_n, 0);
    check("z_req_ack_lo",  z_if.rst_ack,     0);
    wait_until(111);
    check("z_req_fifo_hi", z_if.fifo_wrst_n, 1);
    check("z_req_ack_hi",  z_if.rst_ack,     1);
    wait_until(113);
    check("z_req_wr_block", z_if.wr_allow, 0);
    check("z_req_ack_held", z_if.rst_ack,  1);
    z_if.rst_req = 1'b0;
    wait_until(114);
    check("z_req_wr_allow", z_if.wr_allow,  1);
    check("z_req_ack_rel",  z_if.rst_ack,   0);
    check("z_req_idle",     z_if.busy,      0);
    check("z_req_count",    z_if.rst_count, 2);

    // ---- Every queued expectation must have been matched ----
    wait_until(118);
    check("m_rise_left", m_rise_q.size(), 0);
    check("m_ack_left",  m_ack_q.size(),  0);
    check("s_ack_left",  s_ack_q.size(),  0);
    check("z_rise_left", z_rise_q.size(), 0);
    check("z_ack_left",  z_ack_q.size(),  0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/wrst_sequencer.md
# wrst_sequencer

Write-domain reset sequencer for the async FIFO environment. It produces the FIFO write-side active-low reset `fifo_wrst_n` with a guaranteed assertion length, then holds a write-permit low for a programmable recovery window. It runs one assertion sequence automatically after its own reset and one more per accepted request on a four-phase `rst_req`/`rst_ack` handshake. It sits directly upstream of the write-domain reset input `wrst_n` of the FIFO reset interface, and it gates the write traffic generator through `wr_allow`.

## Interface
- `ASSERT_CYCLES`, 4: number of `wclk` cycles `fifo_wrst_n` is held low per requested sequence; must be ≥1 and ≤2^`CNT_W`.
- `RECOVERY_CYCLES`, 2: number of cycles after deassertion during which writes stay blocked; must be ≥0 and ≤2^`CNT_W`.
- `CNT_W`, 8: width of the internal cycle counter.
- `CNT_OUT_W`, 16: width of the completed-sequence counter.

Ports:
- `wclk` in 1: the single clock. All logic is on its rising edge.
- `wrst` in 1: synchronous, active-high reset of this block.
- `rst_req` in 1: level request for a reset sequence (four-phase handshake).
- `rst_ack` out 1: high while a completed sequence is acknowledged.
- `fifo_wrst_n` out 1: active-low reset driven to the FIFO write domain.
- `wr_allow` out 1: high when the write side may issue writes.
- `busy` out 1: high in any state other than IDLE.
- `rst_count` out `CNT_OUT_W`: number of completed sequences, including the post-reset sequence; saturates at all-ones.

## Operation
- **FSM states:** IDLE, ASSERT, RECOVER, DONE.
- **Output decode:** all outputs are registered or decoded from the state register only. No combinational path from `rst_req` to any output.
  - `fifo_wrst_n` = 0 only in ASSERT.
  - `wr_allow` = 1 only in IDLE.
  - `rst_ack` = 1 only in DONE.
  - `busy` = 0 only in IDLE.
- **Reset (`wrst`=1 at an edge):** state = ASSERT, cnt = `ASSERT_CYCLES`-1, `rst_count` = 0. Resulting outputs: `fifo_wrst_n`=0, `wr_allow`=0, `busy`=1, `rst_ack`=0. `wrst` overrides every other input and any state, including mid-sequence. The sequence restarts from this point.
- **IDLE:** if `rst_req`=1, go to ASSERT with cnt = `ASSERT_CYCLES`-1. Otherwise stay.
- **ASSERT:** if cnt≠0, decrement cnt. If cnt=0:
  - go to RECOVER with cnt = `RECOVERY_CYCLES`-1 when `RECOVERY_CYCLES`>0;
  - otherwise go directly to DONE.
- **RECOVER:** if cnt≠0, decrement. If cnt=0, go to DONE.
- **Entry to DONE:** `rst_count` increments by 1, saturating at 2^`CNT_OUT_W`-1 (no wrap).
- **DONE:** stay while `rst_req`=1. Go to IDLE on the first edge with `rst_req`=0. DONE always lasts ≥1 cycle, so the post-reset sequence (no request pending) gives a 1-cycle `rst_ack` pulse.
- **`rst_req` outside IDLE:** ignored in ASSERT and RECOVER. It does not extend or restart the sequence.
- **Back-to-back requests:** a new sequence requires `rst_req` to drop, the FSM to pass through IDLE, and `rst_req` to rise again. Minimum IDLE dwell is 1 cycle.
- **Counter width:** cnt is `CNT_W` bits and only ever loads values ≤2^`CNT_W`-1, so no wrap occurs.

## Timing
- **Request at edge k** (`rst_req` sampled 1 in IDLE):
  - after edge k: `fifo_wrst_n`=0, `wr_allow`=0, `busy`=1;
  - `fifo_wrst_n` returns to 1 after edge k+`ASSERT_CYCLES`, i.e. low for exactly `ASSERT_CYCLES` cycles;
  - `rst_ack` rises after edge k+`ASSERT_CYCLES`+`RECOVERY_CYCLES`.
- **Handshake release:** `rst_req` dropped and sampled 0 at edge m (in DONE). After edge m: `rst_ack`=0, `wr_allow`=1, `busy`=0.
- **Post-reset sequence:** let j be the last edge with `wrst`=1. Timing equals a request accepted at edge j:
  - `fifo_wrst_n` rises after edge j+`ASSERT_CYCLES`;
  - `rst_ack` is high for one cycle after edge j+`ASSERT_CYCLES`+`RECOVERY_CYCLES`;
  - `wr_allow` rises one edge later, provided `rst_req`=0.
- **`RECOVERY_CYCLES`=0:** ASSERT goes straight to DONE. `fifo_wrst_n` and `rst_ack` rise on the same edge.

## Test plan
All scenarios use `ASSERT_CYCLES`=4 and `RECOVERY_CYCLES`=2.

- **Power-on:** hold `wrst` 3 cycles, then release with `rst_req`=0.
  - `fifo_wrst_n` is low through edge j+3 and high after j+4.
  - `rst_ack` is high only after j+6.
  - `wr_allow` is 1 from j+7.
  - `rst_count`=1.
- **Single request:** raise `rst_req` in IDLE at edge k, hold it 10 cycles.
  - `fifo_wrst_n` is low for exactly 4 cycles.
  - `rst_ack` is high from k+6 until one edge after `rst_req` is sampled 0.
  - `rst_count` increments by 1.
- **Request jitter:** toggle `rst_req` 1→0→1 during ASSERT/RECOVER.
  - The sequence length is unchanged at 4+2.
  - There is exactly one DONE entry.
- **Mid-sequence reset:** assert `wrst` for 1 cycle on the 2nd ASSERT cycle of a requested sequence.
  - `rst_count` becomes 0, then becomes 1 after the restarted post-reset sequence.
  - `fifo_wrst_n` stays low continuously until j+4.
- **Saturation (`CNT_OUT_W`=2):** run 5 request handshakes after reset. `rst_count` reads 1, 2, 3, 3, 3, 3.
- **`RECOVERY_CYCLES`=0 build:**
  - `fifo_wrst_n` and `rst_ack` rise together at k+4.
  - `wr_allow` rises one edge after `rst_req` is sampled 0.
